// File: rtl/bootrom_arb.sv
// Round-robin arbiter sharing one in-order req/gnt/rvalid slave between NUM_REQ masters.
// Owners of outstanding requests are kept in an in-order FIFO so responses route back.
module bootrom_arb #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    m_req_i,
  input  logic [NUM_REQ-1:0]    m_we_i,
  input  logic [NUM_REQ*4-1:0]  m_be_i,
  input  logic [NUM_REQ*32-1:0] m_addr_i,
  input  logic [NUM_REQ*32-1:0] m_data_i,
  output logic [NUM_REQ-1:0]    m_gnt_o,
  output logic [NUM_REQ-1:0]    m_rvalid_o,
  output logic [NUM_REQ*32-1:0] m_data_o,
  output logic                  s_req_o,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [31:0]           s_addr_o,
  output logic [31:0]           s_data_o,
  input  logic                  s_gnt_i,
  input  logic                  s_rvalid_i,
  input  logic [31:0]           s_data_i,
  output logic                  err_o
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(MAX_OUTST + 1);
  localparam int unsigned PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] head;
  logic           any_req, room, accept, pop;
  logic [IDW-1:0] owner_q [MAX_OUTST];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           err_q, err_d;

  // First requester at or after the rr pointer, wrapping modulo NUM_REQ.
  always_comb begin
    win     = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDW'((32'(rr_q) + i) % NUM_REQ);
      if (!any_req && m_req_i[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

  assign room   = (count_q < CW'(MAX_OUTST));
  assign accept = s_req_o & s_gnt_i;
  assign pop    = s_rvalid_i & (count_q != '0);
  assign head   = owner_q[rd_ptr_q];

  always_comb begin
    s_req_o  = room & any_req;
    s_we_o   = 1'b0;
    s_be_o   = '0;
    s_addr_o = '0;
    s_data_o = '0;
    m_gnt_o  = '0;
    if (any_req) begin
      s_we_o   = m_we_i[win];
      s_be_o   = m_be_i[32'(win)*4 +: 4];
      s_addr_o = m_addr_i[32'(win)*32 +: 32];
      s_data_o = m_data_i[32'(win)*32 +: 32];
    end
    if (accept) m_gnt_o[win] = 1'b1;
  end

  always_comb begin
    m_rvalid_o = '0;
    m_data_o   = '0;
    if (pop) begin
      m_rvalid_o[head]             = 1'b1;
      m_data_o[32'(head)*32 +: 32] = s_data_i;
    end
  end

  always_comb begin
    rr_d     = rr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q | (s_rvalid_i & (count_q == '0));
    count_d  = count_q + CW'(accept) - CW'(pop);
    if (accept) begin
      rr_d     = (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
      wr_ptr_d = (32'(wr_ptr_q) == MAX_OUTST - 1) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = (32'(rd_ptr_q) == MAX_OUTST - 1) ? '0 : rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Owner storage needs no reset: count/pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) owner_q[wr_ptr_q] <= win;
  end

  assign err_o = err_q;

endmodule
